// File: rtl/avalon_mem_master.sv
// Avalon-MM bus master: turns one core load/store into one Avalon transfer,
// stalls on waitrequest, flags misaligned accesses and bus timeouts, and
// returns lane-extracted, sign/zero-extended load data.
module avalon_mem_master #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [31:0]      rdata_q;
  logic [1:0]       lane_q, size_q;
  logic             signed_q, write_q, err_q;
  logic             misalign, timeout_hit;
  logic [3:0]       be_calc;
  logic [31:0]      shifted;

  // Size 3 is reserved and always rejected alongside unaligned half/word.
  assign misalign = (req_size == 2'd3)
                  | ((req_size == 2'd1) & req_addr[0])
                  | ((req_size == 2'd2) & (|req_addr[1:0]));

  assign cnt_inc     = cnt + 1'b1;
  // Abort on the wait cycle that brings the count up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && waitrequest && (cnt_inc == TO_CNT);

  // Byte-lane enables for the accepted request (little-endian lanes).
  always_comb begin
    be_calc = 4'b1111;
    case (req_size)
      2'd0:    be_calc = 4'b0001 << req_addr[1:0];
      2'd1:    be_calc = req_addr[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = misalign ? RESP : BUS;
      BUS:     if (!waitrequest || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, Avalon output registers, read capture and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      rdata_q    <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            lane_q   <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            err_q    <= misalign;
            rdata_q  <= '0;
            if (!misalign) begin
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= be_calc;
              writedata  <= req_wdata << {req_addr[1:0], 3'b000};
              read       <= !req_write;
              write      <= req_write;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            if (read) rdata_q <= readdata;
            read  <= 1'b0;
            write <= 1'b0;
            cnt   <= '0;
          end else if (timeout_hit) begin
            read  <= 1'b0;
            write <= 1'b0;
            err_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign shifted = rdata_q >> {lane_q, 3'b000};

  // Handshake and response outputs; load data is extended only on success.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = '0;
    if ((state == RESP) && !err_q && !write_q) begin
      case (size_q)
        2'd0:    resp_rdata = {{24{signed_q & shifted[7]}},  shifted[7:0]};
        2'd1:    resp_rdata = {{16{signed_q & shifted[15]}}, shifted[15:0]};
        default: resp_rdata = shifted;
      endcase
    end
  end

endmodule
